// File: rtl/normaliza_redondeo_pf.sv
// Post-adder stage of the FP adder datapath: normalizes the raw extended
// mantissa one bit per cycle, rounds to nearest-even and packs the
// IEEE-754 result. One operation in flight at a time.
module normaliza_redondeo_pf #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic [FRAC_W+3:0]       in_mant,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   out_result
);

  localparam int M_W   = FRAC_W + 4;
  localparam int RES_W = 1 + EXP_W + FRAC_W;

  // Exponent carries one extra bit so that overflow past the all-ones code
  // (infinity) is visible as a plain magnitude compare.
  localparam logic [EXP_W:0] E_ONE = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [EXP_W:0] E_MAX = {1'b0, {EXP_W{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t             state_q;
  logic               sign_q;
  logic [EXP_W:0]     exp_q;
  logic [M_W-1:0]     mant_q;
  logic               out_valid_q;
  logic [RES_W-1:0]   result_q;

  // Round-to-nearest-even on the guard/sticky bits, then pack. A rounding
  // carry out of the mantissa bumps the exponent and leaves the fraction at
  // zero; a denormal that rounds up into the hidden bit becomes normal.
  function automatic logic [RES_W-1:0] round_pack(
    input logic           s,
    input logic [EXP_W:0] e,
    input logic [M_W-1:0] m
  );
    logic               inc;
    logic [FRAC_W+1:0]  sum;
    logic [EXP_W:0]     e_r;
    logic [FRAC_W-1:0]  frac;
    logic               hidden;
    logic [RES_W-1:0]   r;
    inc    = m[1] & (m[0] | m[2]);
    sum    = m[M_W-1:2] + {{(FRAC_W+1){1'b0}}, inc};
    e_r    = e;
    frac   = sum[FRAC_W-1:0];
    hidden = sum[FRAC_W];
    if (sum[FRAC_W+1]) begin
      e_r    = e + E_ONE;
      frac   = '0;
      hidden = 1'b1;
    end
    if (m == '0) begin
      r = {s, {(RES_W-1){1'b0}}};
    end else if (e_r >= E_MAX) begin
      r = {s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (!hidden) begin
      r = {s, {EXP_W{1'b0}}, frac};
    end else begin
      r = {s, e_r[EXP_W-1:0], frac};
    end
    return r;
  endfunction

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = out_valid_q;
  assign out_result = result_q;

  // Control FSM plus operand datapath; reset clears control and the result only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            sign_q  <= in_sign;
            exp_q   <= {1'b0, in_exp};
            mant_q  <= in_mant;
            state_q <= S_NORM;
          end
        end
        S_NORM: begin
          if (mant_q[M_W-1]) begin
            // Carry out of the add: shift right, fold the lost bit into sticky.
            mant_q <= {1'b0, mant_q[M_W-1:2], mant_q[1] | mant_q[0]};
            exp_q  <= exp_q + E_ONE;
          end else if (mant_q == '0) begin
            state_q <= S_ROUND;
          end else if (!mant_q[M_W-2] && (exp_q > E_ONE)) begin
            mant_q <= {mant_q[M_W-2:0], 1'b0};
            exp_q  <= exp_q - E_ONE;
          end else begin
            state_q <= S_ROUND;
          end
        end
        S_ROUND: begin
          result_q    <= round_pack(sign_q, exp_q, mant_q);
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
